// File: rtl/uart_rx_packer.sv
// uart_rx_packer: oversampled UART receiver that packs serial bytes, MSB-first,
// into a NUM_WORDS x WORD_W operand packet and offers it on a valid/ready port.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data bits).
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_IDLE  | line idle, waiting for synced Rx low
// S_START | qualifying the start bit; a high majority is a false start
// S_DATA  | sampling DATA_BITS data bits, LSB first
// S_PARITY| sampling the parity bit (UART_RX_PARITY_EN only)
// S_STOP  | sampling the stop bit, then commit or drop the byte

module uart_rx_packer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int WORD_W     = 32,
    parameter int NUM_WORDS  = 2,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk_50m,
    input  logic                          rst_n,
    input  logic                          clken,
    input  logic                          Rx,
    output logic [NUM_WORDS*WORD_W-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int TOT    = NUM_WORDS * WORD_W;
    localparam int NBYTES = TOT / DATA_BITS;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int BIW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int CW     = $clog2(OVERSAMPLE + 1);
    localparam int MID    = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [BIW-1:0]       r_bit_idx;
    logic [1:0]           r_votes;
    logic [DATA_BITS-1:0] r_scratch;
    logic [BCW-1:0]       r_byte_cnt;
    logic [TOT-1:0]       r_pack;
    logic [TOT-1:0]       r_out_data;
    logic                 r_out_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                 r_parity_err;
    logic                 r_par_bad;
`endif

    logic [CW-1:0]        w_cnt_n;
    logic [CW-1:0]        w_win_lo;
    logic [CW-1:0]        w_win_hi;
    logic                 w_sample;
    logic                 w_decide;
    logic                 w_bit;
    logic                 w_last;
    logic                 w_accept;
    logic [TOT-1:0]       w_pack_nxt;

    // Start bit is timed from the detected falling edge; later bits are timed
    // from the previous decision, which sits one tick past a bit centre, so a
    // full bit period later lands one tick past the next centre.
    always_comb begin
        w_cnt_n  = r_cnt + 1'b1;
        w_win_lo = (r_state == S_START) ? CW'(MID - 1) : CW'(OVERSAMPLE - 2);
        w_win_hi = (r_state == S_START) ? CW'(MID + 1) : CW'(OVERSAMPLE);
        w_sample = (w_cnt_n >= w_win_lo) && (w_cnt_n < w_win_hi);
        w_decide = (w_cnt_n == w_win_hi);
        w_bit    = (r_votes[1] & r_votes[0]) | (r_votes[1] & r_rx_sync) |
                   (r_votes[0] & r_rx_sync);
        w_last   = (r_byte_cnt == BCW'(NBYTES - 1));
        w_accept = r_out_valid & out_ready;
    end

    // Packet image with the byte currently in scratch dropped into its slot.
    always_comb begin
        w_pack_nxt = r_pack;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_byte_cnt == BCW'(k)) begin
                w_pack_nxt[TOT-1-k*DATA_BITS -: DATA_BITS] = r_scratch;
            end
        end
    end

    // Two-flop synchroniser on the asynchronous serial line; idles high.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Receive FSM, byte packer and output handshake.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_votes      <= '0;
            r_scratch    <= '0;
            r_byte_cnt   <= '0;
            r_pack       <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
            r_par_bad    <= 1'b0;
`endif
        end else begin
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            if (clken) begin
                if (r_state != S_IDLE) begin
                    r_cnt <= w_cnt_n;
                    if (w_sample) begin
                        r_votes <= {r_votes[0], r_rx_sync};
                    end
                end
                case (r_state)
                    S_IDLE: begin
                        if (!r_rx_sync) begin
                            r_state <= S_START;
                            r_cnt   <= '0;
                        end
                    end
                    S_START: begin
                        if (w_decide) begin
                            r_cnt <= '0;
                            if (w_bit) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state   <= S_DATA;
                                r_bit_idx <= '0;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_decide) begin
                            r_cnt                <= '0;
                            r_scratch[r_bit_idx] <= w_bit;
                            if (r_bit_idx == BIW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (w_decide) begin
                            r_cnt     <= '0;
                            r_par_bad <= ((^r_scratch) ^ w_bit) != (PARITY_ODD != 0);
                            r_state   <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_decide) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            if (!w_bit) begin
                                r_frame_err <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            else if (r_par_bad) begin
                                r_parity_err <= 1'b1;
                            end
`endif
                            else begin
                                r_pack <= w_pack_nxt;
                                if (w_last) begin
                                    r_byte_cnt <= '0;
                                    if (!r_out_valid || out_ready) begin
                                        r_out_data  <= w_pack_nxt;
                                        r_out_valid <= 1'b1;
                                    end else begin
                                        r_overrun <= 1'b1;
                                    end
                                end else begin
                                    r_byte_cnt <= r_byte_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
